// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port direction indices, default flit width
// and the one-hot output-arbiter state encodings.
package noc_pkg;

  localparam int DIR_N  = 0;
  localparam int DIR_E  = 1;
  localparam int DIR_W  = 2;
  localparam int DIR_S  = 3;
  localparam int DIR_L  = 4;

  localparam int FLIT_W = 32;

  typedef logic [5:0] arb_state_t;

  localparam arb_state_t IDLE = 6'b000001;
  localparam arb_state_t L    = 6'b000010;
  localparam arb_state_t N    = 6'b000100;
  localparam arb_state_t E    = 6'b001000;
  localparam arb_state_t W    = 6'b010000;
  localparam arb_state_t S    = 6'b100000;

endpackage

// File: rtl/noc_fifo_mem.sv
// DEPTH x DATA_WIDTH flit storage: one synchronous write port and one
// asynchronous read port, so the FIFO head is visible without a read cycle.
module noc_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PTR_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/noc_rx_handshake_fifo.sv
// Receive side of the RTS/CTS link: one flit accepted per CTS pulse into a
// circular FIFO popped by any output-arbiter grant. Option: RX_PARITY_EN.
module noc_rx_handshake_fifo
  import noc_pkg::*;
#(
  parameter  int DATA_WIDTH = FLIT_W,
  parameter  int DEPTH      = 4,
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  DRTS,
  output logic                  CTS,
  input  logic [4:0]            rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full,
`ifdef RX_PARITY_EN
  input  logic                  rx_par,
  output logic                  par_err,
`endif
  output logic [PTR_W:0]        count
);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             cts_next;
  logic             wr_en;
  logic             rd_valid;

  // The ~CTS term makes CTS a one-cycle pulse per handshake.
  assign cts_next = DRTS & ~CTS & ~full;
  assign rd_valid = (|rd_en) & ~empty;
  assign empty    = (count == '0);
  assign full     = (count == (PTR_W+1)'(DEPTH));

`ifdef RX_PARITY_EN
  logic par_ok;

  // A bad flit is still acknowledged so upstream never stalls, just not stored.
  assign par_ok = ~(^{RX, rx_par});
  assign wr_en  = cts_next & par_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_err <= 1'b0;
    end else if (cts_next && !par_ok) begin
      par_err <= 1'b1;
    end
  end
`else
  assign wr_en = cts_next;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      CTS    <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      CTS <= cts_next;
      if (wr_en) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rd_valid) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({wr_en, rd_valid})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  noc_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (RX),
    .raddr (rd_ptr),
    .rdata (dout)
  );

  // Multiple simultaneous grants are an arbiter bug; they still pop only once.
  a_single_grant : assert property (@(posedge clk) disable iff (rst) $onehot0(rd_en))
    else $error("noc_rx_handshake_fifo: multiple rd_en grants 0b%05b", rd_en);

endmodule

// File: tb/tb_noc_rx_handshake_fifo.sv
// Directed table-driven bench for noc_rx_handshake_fifo (DEPTH=4, 32-bit flits),
// plus hand-written sequences for wrap, empty pop, reset and parity.
module tb_noc_rx_handshake_fifo;

  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] RX;
  logic          DRTS;
  logic          CTS;
  logic [4:0]    rd_en;
  logic [DW-1:0] dout;
  logic          empty;
  logic          full;
  logic [2:0]    count;
`ifdef RX_PARITY_EN
  logic          rx_par;
  logic          par_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  noc_rx_handshake_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .RX      (RX),
    .DRTS    (DRTS),
    .CTS     (CTS),
    .rd_en   (rd_en),
    .dout    (dout),
    .empty   (empty),
    .full    (full),
`ifdef RX_PARITY_EN
    .rx_par  (rx_par),
    .par_err (par_err),
`endif
    .count   (count)
  );

  typedef struct {
    logic          drts;
    logic [31:0]   rx;
    logic [4:0]    rd;
    logic          cts;
    logic [2:0]    cnt;
    logic          emp;
    logic          ful;
    logic [31:0]   dout;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input logic drts, input logic [31:0] rx, input logic [4:0] rd);
    DRTS  = drts;
    RX    = rx;
    rd_en = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic cts, input logic [2:0] cnt,
                             input logic emp, input logic ful);
    check({tag, ".CTS"},   32'(CTS),   32'(cts));
    check({tag, ".count"}, 32'(count), 32'(cnt));
    check({tag, ".empty"}, 32'(empty), 32'(emp));
    check({tag, ".full"},  32'(full),  32'(ful));
  endtask

  logic [31:0] model_mem [DEPTH];
  int          model_wr;
  int          model_rd;
  logic [31:0] q [$];
  logic [31:0] val;

  initial begin
    // drts, rx, rd_en -> CTS, count, empty, full, dout
    vecs[0]  = '{1'b1, 32'hA5A5_0001, 5'b00000, 1'b1, 3'd1, 1'b0, 1'b0, 32'hA5A5_0001};
    vecs[1]  = '{1'b1, 32'hA5A5_0002, 5'b00000, 1'b0, 3'd1, 1'b0, 1'b0, 32'hA5A5_0001};
    vecs[2]  = '{1'b1, 32'hA5A5_0002, 5'b00000, 1'b1, 3'd2, 1'b0, 1'b0, 32'hA5A5_0001};
    vecs[3]  = '{1'b1, 32'hA5A5_0003, 5'b00000, 1'b0, 3'd2, 1'b0, 1'b0, 32'hA5A5_0001};
    vecs[4]  = '{1'b1, 32'hA5A5_0003, 5'b00000, 1'b1, 3'd3, 1'b0, 1'b0, 32'hA5A5_0001};
    vecs[5]  = '{1'b1, 32'hA5A5_0004, 5'b00000, 1'b0, 3'd3, 1'b0, 1'b0, 32'hA5A5_0001};
    vecs[6]  = '{1'b1, 32'hA5A5_0004, 5'b00000, 1'b1, 3'd4, 1'b0, 1'b1, 32'hA5A5_0001};
    vecs[7]  = '{1'b1, 32'hA5A5_0005, 5'b00000, 1'b0, 3'd4, 1'b0, 1'b1, 32'hA5A5_0001};
    vecs[8]  = '{1'b1, 32'hA5A5_0005, 5'b00000, 1'b0, 3'd4, 1'b0, 1'b1, 32'hA5A5_0001};
    vecs[9]  = '{1'b1, 32'hA5A5_0005, 5'b00000, 1'b0, 3'd4, 1'b0, 1'b1, 32'hA5A5_0001};
    vecs[10] = '{1'b1, 32'hA5A5_0005, 5'b00001, 1'b0, 3'd3, 1'b0, 1'b0, 32'hA5A5_0002};
    vecs[11] = '{1'b1, 32'hA5A5_0005, 5'b00000, 1'b1, 3'd4, 1'b0, 1'b1, 32'hA5A5_0002};
    vecs[12] = '{1'b0, 32'hA5A5_0005, 5'b00010, 1'b0, 3'd3, 1'b0, 1'b0, 32'hA5A5_0003};
    vecs[13] = '{1'b0, 32'hA5A5_0005, 5'b00100, 1'b0, 3'd2, 1'b0, 1'b0, 32'hA5A5_0004};

`ifdef RX_PARITY_EN
    rx_par = 1'b0;
`endif
    rst = 1'b1;
    step(1'b0, 32'h0, 5'b0);
    step(1'b0, 32'h0, 5'b0);
    check_state("reset", 1'b0, 3'd0, 1'b1, 1'b0);
    rst = 1'b0;

    // Single accept, fill to full with DRTS held, pop from full, drain to 2.
    foreach (vecs[i]) begin
      step(vecs[i].drts, vecs[i].rx, vecs[i].rd);
      check_state($sformatf("vec%0d", i), vecs[i].cts, vecs[i].cnt, vecs[i].emp, vecs[i].ful);
      check($sformatf("vec%0d.dout", i), dout, vecs[i].dout);
      $display("vec%0d drts=%0b rd_en=%05b cts=%0b count=%0d dout=%08h",
               i, vecs[i].drts, vecs[i].rd, CTS, count, dout);
    end

    // Known contents after the table: rd_ptr=3, wr_ptr=1, two entries live.
    model_mem[0] = 32'hA5A5_0005;
    model_mem[1] = 32'hA5A5_0002;
    model_mem[2] = 32'hA5A5_0003;
    model_mem[3] = 32'hA5A5_0004;
    model_wr = 1;
    model_rd = 3;
    q.push_back(32'hA5A5_0004);
    q.push_back(32'hA5A5_0005);

    // Simultaneous write and pop at count=2; pointers wrap twice.
    for (int t = 0; t < 8; t++) begin
      val = 32'hC0DE_0000 + 32'(t);
      step(1'b1, val, 5'(1 << (t % 5)));
      model_mem[model_wr] = val;
      model_wr = (model_wr + 1) % DEPTH;
      model_rd = (model_rd + 1) % DEPTH;
      q.push_back(val);
      void'(q.pop_front());
      check_state($sformatf("wr_rd%0d", t), 1'b1, 3'd2, 1'b0, 1'b0);
      check($sformatf("wr_rd%0d.dout", t), dout, q[0]);
      check($sformatf("wr_rd%0d.dout_mem", t), dout, model_mem[model_rd]);
      $display("wr_rd%0d rx=%08h count=%0d dout=%08h", t, val, count, dout);
      step(1'b1, val, 5'b0);
      check($sformatf("wr_rd%0d.cts_low", t), 32'(CTS), 32'd0);
      check($sformatf("wr_rd%0d.hold", t), 32'(count), 32'd2);
    end

    // Drain the remaining two entries in order.
    for (int t = 0; t < 2; t++) begin
      step(1'b0, 32'h0, 5'b01000);
      void'(q.pop_front());
      model_rd = (model_rd + 1) % DEPTH;
      check($sformatf("drain%0d.count", t), 32'(count), 32'(1 - t));
      if (t == 0) check("drain0.dout", dout, q[0]);
      $display("drain%0d count=%0d empty=%0b", t, count, empty);
    end
    check("drain.empty", 32'(empty), 32'd1);

    // Pop while empty is ignored; head stays on the stale slot.
    step(1'b0, 32'h0, 5'b10000);
    check_state("empty_pop", 1'b0, 3'd0, 1'b1, 1'b0);
    check("empty_pop.dout", dout, model_mem[model_rd]);
    $display("empty_pop count=%0d empty=%0b dout=%08h", count, empty, dout);

    // Next write goes to the slot after the wrapped pointer.
    step(1'b1, 32'hBEEF_0001, 5'b0);
    check_state("post_empty_wr", 1'b1, 3'd1, 1'b0, 1'b0);
    check("post_empty_wr.dout", dout, 32'hBEEF_0001);
    $display("post_empty_wr count=%0d dout=%08h", count, dout);
    step(1'b0, 32'h0, 5'b0);

    // Reset during a would-be handshake drops it; request is served afterwards.
    rst = 1'b1;
    step(1'b1, 32'hBEEF_0002, 5'b0);
    check_state("rst_mid", 1'b0, 3'd0, 1'b1, 1'b0);
    rst = 1'b0;
    step(1'b1, 32'hBEEF_0003, 5'b0);
    check_state("rst_after", 1'b1, 3'd1, 1'b0, 1'b0);
    check("rst_after.dout", dout, 32'hBEEF_0003);
    $display("rst_after cts=%0b count=%0d dout=%08h", CTS, count, dout);

`ifdef RX_PARITY_EN
    rst = 1'b1;
    step(1'b0, 32'h0, 5'b0);
    rst = 1'b0;
    rx_par = 1'b0;
    step(1'b1, 32'h0000_0001, 5'b0);
    check_state("par_bad", 1'b1, 3'd0, 1'b1, 1'b0);
    check("par_bad.err", 32'(par_err), 32'd1);
    step(1'b0, 32'h0, 5'b0);
    rx_par = 1'b1;
    step(1'b1, 32'h0000_0001, 5'b0);
    check_state("par_good", 1'b1, 3'd1, 1'b0, 1'b0);
    check("par_good.err", 32'(par_err), 32'd1);
    check("par_good.dout", dout, 32'h0000_0001);
    rst = 1'b1;
    step(1'b0, 32'h0, 5'b0);
    rst = 1'b0;
    check("par_rst.err", 32'(par_err), 32'd0);
    $display("parity par_err=%0b count=%0d", par_err, count);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
